alu_muldiv: RTL

//  Iterative multiply/divide execute unit (RV32M: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).

---
 rtl/alu_muldiv.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per clock, with sign fix-up and single-cycle divide special cases.
module alu_muldiv #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic                  Flush,
  input  logic [OP_WIDTH-1:0]   MulDivOp,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Zero
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                r_state;
  logic [OP_WIDTH-1:0]   r_op;
  logic [W-1:0]          r_b;
  logic [2*W-1:0]        r_acc;
  logic [CW-1:0]         r_cnt;
  logic                  r_neg;
  logic                  r_neg_rem;
  logic [W-1:0]          r_result;
  logic                  r_done;

  logic                  w_is_div;
  logic                  w_sign_a;
  logic                  w_sign_b;
  logic [W-1:0]          w_a_abs;
  logic [W-1:0]          w_b_abs;
  logic                  w_b_zero;
  logic                  w_ovf;
  logic [W-1:0]          w_special_res;
  logic [W:0]            w_sum;
  logic [W:0]            w_rem_sh;
  logic                  w_ge;
  logic [W-1:0]          w_sub;
  logic [2*W-1:0]        w_prod;
  logic [W-1:0]          w_quo;
  logic [W-1:0]          w_rem;
  logic [W-1:0]          w_fix_res;

  assign w_is_div = MulDivOp[2];

  // Signedness per operand: MULH both, MULHSU A only, DIV/REM both, rest unsigned.
  always_comb begin
    w_sign_a = 1'b0;
    w_sign_b = 1'b0;
    if (w_is_div) begin
      w_sign_a = ~MulDivOp[0];
      w_sign_b = ~MulDivOp[0];
    end else begin
      w_sign_a = (MulDivOp[1:0] == 2'b01) || (MulDivOp[1:0] == 2'b10);
      w_sign_b = (MulDivOp[1:0] == 2'b01);
    end
  end

  assign w_a_abs  = (w_sign_a && SrcA[W-1]) ? (~SrcA + 1'b1) : SrcA;
  assign w_b_abs  = (w_sign_b && SrcB[W-1]) ? (~SrcB + 1'b1) : SrcB;
  assign w_b_zero = (SrcB == '0);
  assign w_ovf    = ~MulDivOp[0] && (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);

  always_comb begin
    w_special_res = '0;
    if (w_b_zero)
      w_special_res = MulDivOp[1] ? SrcA : '1;
    else if (w_ovf)
      w_special_res = MulDivOp[1] ? '0 : SrcA;
  end

  // One multiply step: conditional add into the high half, then shift right with carry.
  assign w_sum = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_b};

  // One restoring-divide step on the left-shifted remainder (needs W+1 bits).
  assign w_rem_sh = r_acc[2*W-1:W-1];
  assign w_ge     = (w_rem_sh >= {1'b0, r_b});
  assign w_sub    = w_rem_sh[W-1:0] - r_b;

  assign w_prod = r_neg ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_neg ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0];
  assign w_rem  = r_neg_rem ? (~r_acc[2*W-1:W] + 1'b1) : r_acc[2*W-1:W];

  always_comb begin
    w_fix_res = '0;
    if (r_op[2])
      w_fix_res = r_op[1] ? w_rem : w_quo;
    else if (r_op[1:0] == 2'b00)
      w_fix_res = w_prod[W-1:0];
    else
      w_fix_res = w_prod[2*W-1:W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
      r_done    <= 1'b0;
    end else if (Flush) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (Start) begin
            r_op      <= MulDivOp;
            r_neg     <= (w_sign_a && SrcA[W-1]) ^ (w_sign_b && SrcB[W-1]);
            r_neg_rem <= w_sign_a && SrcA[W-1];
            if (w_is_div && (w_b_zero || w_ovf)) begin
              r_result <= w_special_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_acc   <= w_is_div ? {{W{1'b0}}, w_a_abs} : {{W{1'b0}}, w_b_abs};
              r_b     <= w_is_div ? w_b_abs : w_a_abs;
              r_cnt   <= CW'(W - 1);
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (r_op[2])
            r_acc <= w_ge ? {w_sub, r_acc[W-2:0], 1'b1}
                          : {w_rem_sh[W-1:0], r_acc[W-2:0], 1'b0};
          else
            r_acc <= r_acc[0] ? {w_sum, r_acc[W-1:1]} : {1'b0, r_acc[2*W-1:1]};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0)
            r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy   = (r_state != S_IDLE);
  assign Done   = r_done;
  assign Result = r_result;
  assign Zero   = (r_result == '0);

endmodule
